// File: rtl/button_pulser.sv
// Two-button front end: synchronise, debounce and turn each accepted press into a
// single-cycle shift pulse, with a left-priority lockout between the two buttons.

module button_pulser_chan #(
  parameter int unsigned          CNT_WIDTH       = 20,
  parameter logic [CNT_WIDTH-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic s2_i,
  input  logic force_idle_i,
  output logic held_o,
  output logic accept_o,
  output logic pulse_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 acc_q, pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= accept_o;
      pulse_q <= acc_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    if (force_idle_i) begin
      // The other channel owns the shifter; restart from scratch once it lets go.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (s2_i) begin
            state_d = ARMING;
            cnt_d   = ONE;
          end
        end
        ARMING: begin
          if (!s2_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEBOUNCE_CYCLES) begin
            state_d  = HELD;
            cnt_d    = '0;
            accept_o = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        HELD: begin
          if (!s2_i) begin
            state_d = RELEASING;
            cnt_d   = ONE;
          end
        end
        RELEASING: begin
          if (s2_i) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEBOUNCE_CYCLES) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign held_o  = (state_q == HELD) || (state_q == RELEASING);
  assign pulse_o = pulse_q;

endmodule

module button_pulser #(
  parameter int unsigned          CNT_WIDTH       = 20,
  parameter logic [CNT_WIDTH-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic       shift_left,
  output logic       shift_right,
  output logic [1:0] held
);

  // Bit 1 = left, bit 0 = right, matching the held output.
  logic [1:0] s1_q, s2_q;
  logic       held_l, held_r, acc_l, acc_r, force_l, force_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= {btn_left_raw, btn_right_raw};
      s2_q <= s1_q;
    end
  end

  // Left also blocks right on the very edge it accepts, so left wins a tie.
  assign force_l = held_r;
  assign force_r = held_l | acc_l;

  button_pulser_chan #(
    .CNT_WIDTH      (CNT_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk         (clk),
    .reset       (reset),
    .s2_i        (s2_q[1]),
    .force_idle_i(force_l),
    .held_o      (held_l),
    .accept_o    (acc_l),
    .pulse_o     (shift_left)
  );

  button_pulser_chan #(
    .CNT_WIDTH      (CNT_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk         (clk),
    .reset       (reset),
    .s2_i        (s2_q[0]),
    .force_idle_i(force_r),
    .held_o      (held_r),
    .accept_o    (acc_r),
    .pulse_o     (shift_right)
  );

  assign held = {held_l, held_r};

endmodule

// File: tb/tb_button_pulser.sv
// Randomised and directed bench for button_pulser at DEBOUNCE_CYCLES=4 and =1, checked
// every cycle against a run-length model of the debounce/lockout rules.

module tb_button_pulser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_l = 1'b0, btn_r = 1'b0;
  logic       sl0, sr0, sl1, sr1;
  logic [1:0] hd0, hd1;

  always #5 clk = ~clk;

  button_pulser #(.CNT_WIDTH(3), .DEBOUNCE_CYCLES(3'd4)) u_dut4 (
    .clk(clk), .reset(rst), .btn_left_raw(btn_l), .btn_right_raw(btn_r),
    .shift_left(sl0), .shift_right(sr0), .held(hd0)
  );

  button_pulser #(.CNT_WIDTH(1), .DEBOUNCE_CYCLES(1'd1)) u_dut1 (
    .clk(clk), .reset(rst), .btn_left_raw(btn_l), .btn_right_raw(btn_r),
    .shift_left(sl1), .shift_right(sr1), .held(hd1)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model state per instance [i] and channel [c] (c=1 left, c=0 right).
  bit m_s1 [2][2], m_s2 [2][2], m_held [2][2], m_acc [2][2], m_pulse [2][2];
  int m_run [2][2];
  int pc [2][2];
  int first_l_cyc;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // A channel flips its debounced state after d+1 consecutive contradicting samples;
  // a held channel zeroes the other one, and left beats right on a tied acceptance.
  task automatic model_step(input int i, input int d);
    bit nh [2];
    bit acc [2];
    int nr [2];
    bit raw [2];
    raw[1] = btn_l;
    raw[0] = btn_r;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[i][c] = 0; m_s2[i][c] = 0; m_held[i][c] = 0;
        m_acc[i][c] = 0; m_pulse[i][c] = 0; m_run[i][c] = 0;
      end
      return;
    end
    for (int c = 0; c < 2; c++) begin
      nh[c] = m_held[i][c];
      acc[c] = 0;
      nr[c] = (m_s2[i][c] != m_held[i][c]) ? m_run[i][c] + 1 : 0;
      if (nr[c] == d + 1) begin
        nh[c] = !m_held[i][c];
        acc[c] = nh[c];
        nr[c] = 0;
      end
    end
    if (m_held[i][0]) begin nh[1] = 0; nr[1] = 0; acc[1] = 0; end
    if (m_held[i][1] || acc[1]) begin nh[0] = 0; nr[0] = 0; acc[0] = 0; end
    for (int c = 0; c < 2; c++) begin
      m_pulse[i][c] = m_acc[i][c];
      m_acc[i][c]   = acc[c];
      m_held[i][c]  = nh[c];
      m_run[i][c]   = nr[c];
      m_s2[i][c]    = m_s1[i][c];
      m_s1[i][c]    = raw[c];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 1);
    @(negedge clk);
    cyc++;
    chk("d4_shift_left",  {1'b0, sl0}, {1'b0, m_pulse[0][1]});
    chk("d4_shift_right", {1'b0, sr0}, {1'b0, m_pulse[0][0]});
    chk("d4_held",        hd0,         {m_held[0][1], m_held[0][0]});
    chk("d1_shift_left",  {1'b0, sl1}, {1'b0, m_pulse[1][1]});
    chk("d1_shift_right", {1'b0, sr1}, {1'b0, m_pulse[1][0]});
    chk("d1_held",        hd1,         {m_held[1][1], m_held[1][0]});
    if (sl0) begin
      pc[0][1]++;
      if (first_l_cyc < 0) first_l_cyc = cyc;
    end
    if (sr0) pc[0][0]++;
    if (sl1) pc[1][1]++;
    if (sr1) pc[1][0]++;
  endtask

  task automatic run(input bit l, input bit r, input int n);
    btn_l = l;
    btn_r = r;
    repeat (n) cycle();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) pc[i][c] = 0;
    first_l_cyc = -1;
  endtask

  initial begin
    int c0;
    // Reset state.
    rst = 1'b1;
    run(0, 0, 3);
    chk("reset_held", hd0, 2'b00);
    chk("reset_pulses", {sl0, sr0}, 2'b00);
    rst = 1'b0;

    // Clean left press: pulse seen right after edge 7, exactly once.
    clr_counts();
    c0 = cyc;
    run(1, 0, 20);
    chk("clean_pulse_cnt", 2'(pc[0][1]), 2'd1);
    chk("clean_right_cnt", 2'(pc[0][0]), 2'd0);
    chk("clean_pulse_edge", 2'(first_l_cyc - c0 - 6), 2'd2);
    run(0, 0, 20);

    // Bounce on right, then steady.
    clr_counts();
    run(0, 1, 3); run(0, 0, 1); run(0, 1, 2); run(0, 0, 1);
    run(0, 1, 20);
    chk("bounce_pulse_cnt", 2'(pc[0][0]), 2'd1);
    run(0, 0, 20);

    // Long hold, release, re-press: two pulses.
    clr_counts();
    run(1, 0, 100); run(0, 0, 20); run(1, 0, 20); run(0, 0, 20);
    chk("long_hold_cnt", 2'(pc[0][1]), 2'd2);

    // Simultaneous press, then release left while right stays down.
    clr_counts();
    run(1, 1, 20);
    chk("simul_left_cnt",  2'(pc[0][1]), 2'd1);
    chk("simul_right_cnt", 2'(pc[0][0]), 2'd0);
    run(0, 1, 20);
    chk("handover_right_cnt", 2'(pc[0][0]), 2'd1);
    run(0, 0, 20);

    // Reset on the edge where shift_left would rise.
    clr_counts();
    run(1, 0, 7);
    rst = 1'b1;
    cycle();
    chk("midreset_pulse", {sl0, 1'b0}, 2'b00);
    chk("midreset_held", hd0, 2'b00);
    rst = 1'b0;
    c0 = cyc;
    first_l_cyc = -1;
    run(1, 0, 20);
    chk("midreset_repulse_edge", 2'(first_l_cyc - c0 - 6), 2'd2);
    run(0, 0, 20);

    // Single-cycle glitch: no pulse at DEBOUNCE_CYCLES=1.
    clr_counts();
    run(1, 0, 1); run(0, 0, 20);
    chk("d1_glitch_cnt", 2'(pc[1][1]), 2'd0);

    // Randomised bouncy stimulus with occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    run(0, 0, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
# button_pulser

Front-end conditioner for the two push-buttons that drive the LED shifter stage. It synchronises the raw asynchronous button inputs and debounces each one with a stable-time counter. On each debounced press it emits a single-cycle `shift_left` / `shift_right` pulse, which is what the shifter's edge-triggered inputs expect. A mutual lockout guarantees the shifter never sees both directions requested together.

## Interface
- `DEBOUNCE_CYCLES`, default 20'd500000: consecutive stable cycles needed to accept a press or a release (10 ms at 50 MHz); minimum legal value 1.
- `CNT_WIDTH`, default 20: debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the rising edge of `clk` while high.
- `btn_left_raw` input 1: raw left button, asynchronous, bouncy, high = pressed.
- `btn_right_raw` input 1: raw right button, same properties.
- `shift_left` output 1: one-cycle pulse per accepted left press.
- `shift_right` output 1: one-cycle pulse per accepted right press.
- `held` output 2: debounced press state, {left, right}. High while the channel is in HELD or RELEASING.

## Operation
- **Synchroniser.** Each raw input passes through two flops, s1 then s2. Only s2 is used downstream.
- **Channel FSM.** There is one FSM per channel, each with its own counter `cnt`.
  - IDLE: `cnt`=0. If s2=1, go to ARMING with `cnt`=1.
  - ARMING: if s2=0, go to IDLE and clear `cnt`. If s2=1 and `cnt`<DEBOUNCE_CYCLES, increment `cnt`. If s2=1 and `cnt`==DEBOUNCE_CYCLES, go to HELD and clear `cnt`.
  - HELD: if s2=0, go to RELEASING with `cnt`=1. Otherwise stay.
  - RELEASING: if s2=1, return to HELD with no new pulse and clear `cnt`. If s2=0 and `cnt`<DEBOUNCE_CYCLES, increment `cnt`. If s2=0 and `cnt`==DEBOUNCE_CYCLES, go to IDLE.
- **Pulse.** A channel's pulse output is registered. It is high for exactly the one cycle immediately after the ARMING→HELD transition, and low at all other times.
- **Lockout.** While one channel is in HELD or RELEASING, the other channel is forced to IDLE with `cnt`=0 every cycle. If the forced button is still held after the lock clears, it debounces afresh from `cnt`=1.
- **Simultaneous acceptance.** If both channels would take ARMING→HELD on the same edge, left wins. Right is forced to IDLE on that same edge and produces no pulse.
- **No auto-repeat.** Holding a button yields exactly one pulse, regardless of hold length.
- **Counter range.** `cnt` never exceeds DEBOUNCE_CYCLES; there is no wrap-around.

## Timing
- **Reset values.**
  - Both FSMs go to IDLE; all `cnt`=0.
  - Synchroniser flops go to 0.
  - `shift_left`=0, `shift_right`=0, `held`=2'b00.
- **Reset mid-operation.** Any state, including mid-count and mid-pulse, returns to the reset values on the next edge. A pending pulse is dropped.
- **Press latency.** Raw input goes high and stays clean; the first sampling edge is E0.
  - s2=1 after E1.
  - The channel enters ARMING at E2 with `cnt`=1.
  - The channel enters HELD at E(DEBOUNCE_CYCLES+2).
  - The pulse is high in the cycle following edge E(DEBOUNCE_CYCLES+3).
- **Glitch rejection.** Any s2 low cycle during ARMING restarts the count. A press is accepted only after DEBOUNCE_CYCLES+1 consecutive high samples of s2.
- **Release.** Same latency rule as a press, with polarity inverted. `held` drops on the edge where RELEASING→IDLE.
- **Re-press.** The minimum interval between two pulses on one channel is about 2·DEBOUNCE_CYCLES+4 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless stated.
- **Clean press.** Drive `btn_left_raw`=1 steady from edge 0 → `shift_left` high only in the cycle after edge 7. `held`=2'b10 from edge 6. `shift_right` stays 0.
- **Bounce.** Drive `btn_right_raw` high for 3 cycles, low 1, high 2, low 1, then high steady → exactly one `shift_right` pulse, 7 edges after the final rising edge. No earlier pulse.
- **Long hold and release.** Hold left for 100 cycles, release, re-press after 20 cycles → exactly two `shift_left` pulses. `held[1]` drops 6 edges after release.
- **Simultaneous press.** Drive both raw inputs high on the same edge → one `shift_left` pulse, no `shift_right`. Release left only while right stays held → `shift_right` pulses 7 edges after left reaches IDLE.
- **Reset mid-operation.** Assert `reset` on the edge at which `shift_left` would rise → `shift_left` stays 0 and `held`=2'b00. With the input still high after reset deasserts, the pulse appears 8 edges later.
- **Minimum parameter.** With DEBOUNCE_CYCLES=1, a steady press → pulse after edge 4, and a single-cycle high glitch produces no pulse.
